fp_div_sched: RTL and testbench

// - Round-robin scheduler that shares one pipelined fp_div instance among NREQ requesters.
// - Muxes the granted operands into the divider and drives its enable.
// - Tags every issued operation and tracks it through the divider's PIPE_STAGES latency.
// - Returns result, status flags and requester ID on a single registered valid/ready port.

---
 rtl/fp_sched_pkg.sv | 23 ++
 rtl/fp_div_sched_rr_arbiter.sv | 52 +++++
 rtl/fp_div_sched.sv | 152 +++++++++++++++
 tb/tb_fp_div_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// Types shared by the fp_div request scheduler: the issue tag carried alongside the divider
// pipeline and the rounding-mode encoding handed through to fp_div.
package fp_sched_pkg;

    localparam int MAX_NREQ = 8;
    localparam int MAX_IDW  = $clog2(MAX_NREQ);

    // Same encoding as round_t in enum_typedefs_pkg, so modes pass straight through to fp_div.
    typedef enum logic [2:0] {
        RND_NE   = 3'd0,
        RND_TZ   = 3'd1,
        RND_UP   = 3'd2,
        RND_DN   = 3'd3,
        RND_NEAR = 3'd4,
        RND_AWAY = 3'd5
    } round_t;

    typedef struct packed {
        logic               valid;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp_div_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the pointer,
// wrapping; the pointer moves past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic            grant_valid_o,
    output logic [IDW-1:0]  grant_id_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;

    function automatic int wrap_idx(input int base, input int offs);
        int idx;
        idx = base + offs;
        if (idx >= NREQ) idx = idx - NREQ;
        return idx;
    endfunction

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        found         = 1'b0;
        ptr_d         = ptr_q;
        if (enable_i) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_i[wrap_idx(int'(ptr_q), k)]) begin
                    found                             = 1'b1;
                    grant_o[wrap_idx(int'(ptr_q), k)] = 1'b1;
                    grant_id_o                        = IDW'(wrap_idx(int'(ptr_q), k));
                end
            end
        end
        grant_valid_o = found;
        if (found) begin
            ptr_d = (grant_id_o == IDW'(NREQ - 1)) ? '0 : grant_id_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fp_div_sched.sv
// Shares one pipelined fp_div among NREQ requesters: arbitrates, muxes operands, tags each
// issue through the divider latency and presents results on one registered valid/ready port.
module fp_div_sched
    import fp_sched_pkg::*;
#(
    parameter  int SIG_WIDTH   = 23,
    parameter  int EX_WIDTH    = 8,
    parameter  int PIPE_STAGES = 0,
    parameter  int NREQ        = 4,
    localparam int IDW         = $clog2(NREQ),
    localparam int FW          = SIG_WIDTH + EX_WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*FW-1:0] req_a,
    input  logic [NREQ*FW-1:0] req_b,
    input  logic [NREQ*3-1:0]  req_round,
    output logic [FW-1:0]    div_a,
    output logic [FW-1:0]    div_b,
    output round_t           div_round,
    output logic             div_enable,
    input  logic [FW-1:0]    div_z,
    input  logic [7:0]       div_status,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDW-1:0]   res_id,
    output logic [FW-1:0]    res_z,
    output logic [7:0]       res_status,
    output logic [2:0]       inflight
);

    // Handshake: an op issues when req_valid[i] & req_ready[i]; a result retires when
    // res_valid & res_ready. Everything downstream of the arbiter moves only when adv is high.
    logic           adv;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    tag_t           grant_tag, tag_out;

    logic [FW-1:0]  a_q, b_q;
    round_t         round_q;

    logic           res_valid_q, res_valid_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [FW-1:0]  res_z_q, res_z_d;
    logic [7:0]     res_status_q, res_status_d;
    logic [2:0]     inflight_q, inflight_d;

    assign adv        = !res_valid_q || res_ready;
    assign div_enable = adv;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_valid),
        .enable_i      (adv),
        .grant_o       (req_ready),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // With no grant the divider sees the previous operands, so its inputs stay quiet on bubbles.
    always_comb begin
        div_a     = a_q;
        div_b     = b_q;
        div_round = round_q;
        if (grant_valid) begin
            div_a     = req_a[int'(grant_id)*FW +: FW];
            div_b     = req_b[int'(grant_id)*FW +: FW];
            div_round = round_t'(req_round[int'(grant_id)*3 +: 3]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            round_q <= RND_NE;
        end else if (grant_valid) begin
            a_q     <= div_a;
            b_q     <= div_b;
            round_q <= div_round;
        end
    end

    always_comb begin
        grant_tag.valid = grant_valid;
        grant_tag.id    = MAX_IDW'(grant_id);
    end

    generate
        if (PIPE_STAGES == 0) begin : g_comb_tag
            assign tag_out = grant_tag;
        end else begin : g_tag_pipe
            tag_t tag_q [PIPE_STAGES];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_STAGES; i++) tag_q[i] <= '0;
                end else if (adv) begin
                    tag_q[0] <= grant_tag;
                    for (int i = 1; i < PIPE_STAGES; i++) tag_q[i] <= tag_q[i-1];
                end
            end
            assign tag_out = tag_q[PIPE_STAGES-1];
        end
    endgenerate

    always_comb begin
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_z_d      = res_z_q;
        res_status_d = res_status_q;
        if (adv) begin
            res_valid_d = tag_out.valid;
            if (tag_out.valid) begin
                res_id_d     = IDW'(tag_out.id);
                res_z_d      = div_z;
                res_status_d = div_status;
            end
        end
        inflight_d = inflight_q;
        case ({grant_valid, res_valid_q && res_ready})
            2'b10:   inflight_d = inflight_q + 3'd1;
            2'b01:   inflight_d = inflight_q - 3'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_z_q      <= '0;
            res_status_q <= '0;
            inflight_q   <= '0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_z_q      <= res_z_d;
            res_status_q <= res_status_d;
            inflight_q   <= inflight_d;
        end
    end

    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_z      = res_z_q;
    assign res_status = res_status_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_fp_div_sched.sv
// Directed bench for fp_div_sched with PIPE_STAGES=3, NREQ=4, single precision and a
// table-driven three-stage fp_div stand-in.
module tb_fp_div_sched;

    localparam int NREQ = 4;
    localparam int FW   = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*FW-1:0] req_a = '0;
    logic [NREQ*FW-1:0] req_b = '0;
    logic [NREQ*3-1:0] req_round = '0;
    logic [FW-1:0]     div_a, div_b, div_z;
    logic [2:0]        div_round;
    logic              div_enable;
    logic [7:0]        div_status;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [IDW-1:0]    res_id;
    logic [FW-1:0]     res_z;
    logic [7:0]        res_status;
    logic [2:0]        inflight;

    int errors = 0;
    int checks = 0;
    logic [IDW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fp_div_sched #(.SIG_WIDTH(23), .EX_WIDTH(8), .PIPE_STAGES(3), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_round(req_round),
        .div_a(div_a), .div_b(div_b), .div_round(div_round), .div_enable(div_enable),
        .div_z(div_z), .div_status(div_status), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_z(res_z), .res_status(res_status), .inflight(inflight)
    );

    // Divider stand-in: hand-computed quotients for the operand pairs used below.
    function automatic logic [39:0] div_lookup(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40C00000, 32'h40400000}: return {32'h40000000, 8'h00};
            {32'h41000000, 32'h40000000}: return {32'h40800000, 8'h00};
            {32'h3F800000, 32'h3F800000}: return {32'h3F800000, 8'h00};
            {32'h40400000, 32'h40000000}: return {32'h3FC00000, 8'h00};
            {32'h3F800000, 32'h00000000}: return {32'h7F800000, 8'h82};
            default:                      return {32'hFFC00000, 8'h01};
        endcase
    endfunction

    wire        resetn = !reset;
    logic [39:0] m_pipe [3];
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) m_pipe[i] <= '0;
        end else if (div_enable) begin
            m_pipe[0] <= div_lookup(div_a, div_b);
            m_pipe[1] <= m_pipe[0];
            m_pipe[2] <= m_pipe[1];
        end
    end
    assign div_z      = m_pipe[2][39:8];
    assign div_status = m_pipe[2][7:0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
        req_a[i*FW +: FW] = a;
        req_b[i*FW +: FW] = b;
        req_round[i*3 +: 3] = r;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_z !== 32'h0) begin errors++; $display("FAIL reset_res_z got=%h exp=0", res_z); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
        checks++; if (res_status !== 8'h0) begin errors++; $display("FAIL reset_res_status got=%h exp=0", res_status); end
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        step();
        checks++; if (div_enable !== 1'b1) begin errors++; $display("FAIL reset_div_enable got=%b exp=1", div_enable); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_full_load();
        logic [31:0] zexp [4];
        logic [IDW-1:0] id_e;
        zexp[0] = 32'h40000000; zexp[1] = 32'h40800000; zexp[2] = 32'h3F800000; zexp[3] = 32'h3FC00000;
        for (int k = 0; k <= 12; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            checks++;
            if (req_ready !== ((k < 8) ? 4'(1 << (k % 4)) : 4'h0)) begin
                errors++; $display("FAIL full_grant k=%0d got=%b exp=%b", k, req_ready, (k < 8) ? 4'(1 << (k % 4)) : 4'h0);
            end
            if (k < 8) exp_q.push_back(IDW'(k % 4));
            checks++;
            if (res_valid !== (k >= 4 && k < 12)) begin
                errors++; $display("FAIL full_valid k=%0d got=%b exp=%b", k, res_valid, (k >= 4 && k < 12));
            end
            if (res_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL full_extra k=%0d got id=%0d exp none", k, res_id);
                end else begin
                    id_e = exp_q.pop_front();
                    if (res_id !== id_e || res_z !== zexp[id_e]) begin
                        errors++; $display("FAIL full_result k=%0d got id=%0d z=%h exp id=%0d z=%h", k, res_id, res_z, id_e, zexp[id_e]);
                    end
                end
            end
            if (k == 6) begin
                checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_inflight got=%0d exp=4", inflight); end
            end
            if (k < 12) step();
        end
        checks++; if (inflight !== 3'd0 || exp_q.size() != 0) begin errors++; $display("FAIL full_drain got inflight=%0d left=%0d exp 0 0", inflight, exp_q.size()); end
        step();
    endtask

    task automatic test_single_op();
        set_op(0, 32'h40C00000, 32'h40400000, 3'd0);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001 || div_a !== 32'h40C00000 || div_round !== 3'd0) begin
            errors++; $display("FAIL single_issue got ready=%b a=%h rnd=%0d exp 0001 40c00000 0", req_ready, div_a, div_round);
        end
        step();
        req_valid = 4'b0000;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early c=%0d got=%b exp=0", k, res_valid); end
            step();
        end
        checks++; if (res_valid !== 1'b1 || res_z !== 32'h40000000 || res_id !== 2'd0 || res_status !== 8'h00) begin
            errors++; $display("FAIL single_result got v=%b z=%h id=%0d st=%h exp 1 40000000 0 00", res_valid, res_z, res_id, res_status);
        end
        step();
        checks++; if (res_valid !== 1'b0 || inflight !== 3'd0) begin
            errors++; $display("FAIL single_retire got v=%b inflight=%0d exp 0 0", res_valid, inflight);
        end
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_issue got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b0000;
        repeat (3) step();
        checks++; if (res_valid !== 1'b1 || res_z !== 32'h40800000 || res_id !== 2'd1) begin
            errors++; $display("FAIL bp_result got v=%b z=%h id=%0d exp 1 40800000 1", res_valid, res_z, res_id);
        end
        req_valid = 4'b0100;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++; if (div_enable !== 1'b0 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_stall j=%0d got en=%b ready=%b exp 0 0000", j, div_enable, req_ready);
            end
            checks++; if (res_valid !== 1'b1 || res_z !== 32'h40800000 || inflight !== 3'd1) begin
                errors++; $display("FAIL bp_hold j=%0d got v=%b z=%h inflight=%0d exp 1 40800000 1", j, res_valid, res_z, inflight);
            end
            if (j < 4) step();
        end
        res_ready = 1'b1;
        #1;
        checks++; if (div_enable !== 1'b1 || req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_release got en=%b ready=%b exp 1 0100", div_enable, req_ready);
        end
        step();
        req_valid = 4'b0000;
        for (int k = 9; k <= 11; k++) begin
            checks++; if (res_valid !== 1'b0 || inflight !== 3'd1) begin
                errors++; $display("FAIL bp_gap c=%0d got v=%b inflight=%0d exp 0 1", k, res_valid, inflight);
            end
            step();
        end
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_z !== 32'h3F800000) begin
            errors++; $display("FAIL bp_next got v=%b id=%0d z=%h exp 1 2 3f800000", res_valid, res_id, res_z);
        end
        step();
        checks++; if (res_valid !== 1'b0 || inflight !== 3'd0) begin
            errors++; $display("FAIL bp_drain got v=%b inflight=%0d exp 0 0", res_valid, inflight);
        end
    endtask

    task automatic test_exception();
        int waited;
        set_op(2, 32'h3F800000, 32'h00000000, 3'd1);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100 || div_b !== 32'h0 || div_round !== 3'd1) begin
            errors++; $display("FAIL exc_issue got ready=%b b=%h rnd=%0d exp 0100 0 1", req_ready, div_b, div_round);
        end
        step();
        req_valid = 4'b0000;
        waited = 0;
        while (res_valid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++; if (res_valid !== 1'b1) begin
            errors++; $display("FAIL exc_timeout got no result after %0d cycles exp result", waited);
        end else if (res_z !== 32'h7F800000 || res_status !== 8'h82 || res_id !== 2'd2) begin
            errors++; $display("FAIL exc_result got z=%h st=%h id=%0d exp 7f800000 82 2", res_z, res_status, res_id);
        end
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL exc_retire got=%b exp=0", res_valid); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0111;
        repeat (3) step();
        req_valid = 4'b0000;
        step();
        checks++; if (res_valid !== 1'b1 || inflight !== 3'd3) begin
            errors++; $display("FAIL rst_pre got v=%b inflight=%0d exp 1 3", res_valid, inflight);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || inflight !== 3'd0 || res_z !== 32'h0) begin
            errors++; $display("FAIL rst_async got v=%b inflight=%0d z=%h exp 0 0 0", res_valid, inflight, res_z);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_stale c=%0d got=%b exp=0", k, res_valid); end
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        repeat (3) step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin
            errors++; $display("FAIL rst_after got v=%b id=%0d exp 1 0", res_valid, res_id);
        end
        step();
    endtask

    task automatic test_sparse();
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL sparse_g3 got=%b exp=1000", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sparse_g1 got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b0000;
        step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_z !== 32'h3FC00000) begin
            errors++; $display("FAIL sparse_r3 got v=%b id=%0d z=%h exp 1 3 3fc00000", res_valid, res_id, res_z);
        end
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL sparse_gap got=%b exp=0", res_valid); end
        step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_z !== 32'h40800000) begin
            errors++; $display("FAIL sparse_r1 got v=%b id=%0d z=%h exp 1 1 40800000", res_valid, res_id, res_z);
        end
        step();
        checks++; if (res_valid !== 1'b0 || inflight !== 3'd0) begin
            errors++; $display("FAIL sparse_drain got v=%b inflight=%0d exp 0 0", res_valid, inflight);
        end
    endtask

    initial begin
        set_op(0, 32'h40C00000, 32'h40400000, 3'd0);
        set_op(1, 32'h41000000, 32'h40000000, 3'd0);
        set_op(2, 32'h3F800000, 32'h3F800000, 3'd0);
        set_op(3, 32'h40400000, 32'h40000000, 3'd0);
        test_reset();
        test_full_load();
        test_single_op();
        test_backpressure();
        test_exception();
        test_reset_mid();
        test_sparse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
